// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : fetch / load-store arbiter for one single-port SRAM
// Rev 1.0
// ============================================================================
module sram_arbiter #(
   parameter int unsigned RAM_SIZE     = 5120,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   // instruction fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   output logic        i_err,
   // load/store data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        d_err,
   // SRAM side
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_hready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE_I = 3'd1,
      ISSUE_D = 3'd2,
      RESP_I  = 3'd3,
      RESP_D  = 3'd4,
      ERR_I   = 3'd5,
      ERR_D   = 3'd6
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  streak;
   logic [3:0]  streak_nxt;
   logic        cur_we;
   logic [31:0] i_word;
   logic [31:0] d_word;
   logic        i_in_range;
   logic        d_in_range;
   logic        resp_done_i;
   logic        resp_done_d;
   logic        arb_en;
   logic        grant_i;
   logic        grant_d;
   logic        unused_addr_lsbs;

   assign i_word     = {2'b00, i_addr[31:2]};
   assign d_word     = {2'b00, d_addr[31:2]};
   assign i_in_range = i_word < RAM_SIZE;
   assign d_in_range = d_word < RAM_SIZE;

   assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

   // Arbitration happens whenever the bus is free or frees up this cycle.
   always_comb begin
      resp_done_i = 1'b0;
      resp_done_d = 1'b0;
      arb_en      = 1'b0;
      grant_d     = 1'b0;
      grant_i     = 1'b0;

      resp_done_i = (state == RESP_I) && mem_hready;
      resp_done_d = (state == RESP_D) && mem_hready;
      arb_en      = (state == IDLE) || (state == ERR_I) || (state == ERR_D) ||
                    resp_done_i || resp_done_d;
      grant_d     = arb_en && d_req && !(i_req && (streak == STREAK_MAX));
      grant_i     = arb_en && i_req && !grant_d;
   end

   always_comb begin
      state_nxt  = state;
      streak_nxt = streak;

      case (state)
         ISSUE_I: state_nxt = RESP_I;
         ISSUE_D: state_nxt = RESP_D;
         default: begin
            if (grant_d) begin
               state_nxt = d_in_range ? ISSUE_D : ERR_D;
            end else if (grant_i) begin
               state_nxt = i_in_range ? ISSUE_I : ERR_I;
            end else if (arb_en) begin
               state_nxt = IDLE;
            end
         end
      endcase

      // Saturating count of data grants that made a pending fetch wait.
      if (grant_d) begin
         if (!i_req) begin
            streak_nxt = 4'd0;
         end else if (streak != STREAK_MAX) begin
            streak_nxt = streak + 4'd1;
         end
      end else if (grant_i) begin
         streak_nxt = 4'd0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= IDLE;
         streak    <= 4'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         cur_we    <= 1'b0;
      end else begin
         state  <= state_nxt;
         streak <= streak_nxt;
         // High only during ISSUE_D, never for a rejected address.
         mem_we <= grant_d && d_in_range && d_we;
         if (grant_d) begin
            mem_addr  <= d_word;
            mem_wdata <= d_wdata;
            cur_we    <= d_we;
         end else if (grant_i) begin
            mem_addr  <= i_word;
         end
      end
   end

   // A response coinciding with reset is dropped rather than reported.
   assign i_ready = !HRESET && (resp_done_i || (state == ERR_I));
   assign i_err   = !HRESET && (state == ERR_I);
   assign i_rdata = (!HRESET && resp_done_i) ? mem_rdata : 32'd0;

   assign d_ready = !HRESET && (resp_done_d || (state == ERR_D));
   assign d_err   = !HRESET && (state == ERR_D);
   assign d_rdata = (!HRESET && resp_done_d && !cur_we) ? mem_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// tb_sram_arbiter : directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;

   localparam int unsigned RAM_SIZE     = 5120;
   localparam int unsigned MAX_D_STREAK = 4;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_hready;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   sram_arbiter #(
      .RAM_SIZE    (RAM_SIZE),
      .MAX_D_STREAK(MAX_D_STREAK)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ready   (i_ready),
      .i_rdata   (i_rdata),
      .i_err     (i_err),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_hready(mem_hready),
      .mem_rdata (mem_rdata)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts a fetch at the current negedge and waits for its completion.
   task automatic i_access(input logic [31:0] addr, input logic [31:0] rexp,
                           input logic eexp, input int lat, input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      i_req  = 1'b1;
      i_addr = addr;
      while (!seen && n < 20) begin
         @(negedge HCLK);
         n++;
         if (n == 1 && !eexp) check({tag, "_maddr"}, mem_addr, {2'b00, addr[31:2]});
         if (i_ready) begin
            seen = 1'b1;
            check({tag, "_lat"}, n, lat);
            check({tag, "_rdata"}, i_rdata, rexp);
            check({tag, "_err"}, i_err, eexp);
            i_req = 1'b0;
         end
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Starts a data access at the current negedge and waits for its completion.
   task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rexp, input logic eexp, input int lat,
                           input string tag);
      int n;
      int we_cnt;
      bit seen;
      n      = 0;
      we_cnt = 0;
      seen   = 1'b0;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      while (!seen && n < 20) begin
         @(negedge HCLK);
         n++;
         if (mem_we) begin
            we_cnt++;
            check({tag, "_we_addr"}, mem_addr, {2'b00, addr[31:2]});
            check({tag, "_we_data"}, mem_wdata, wdata);
         end
         if (d_ready) begin
            seen = 1'b1;
            check({tag, "_lat"}, n, lat);
            check({tag, "_rdata"}, d_rdata, rexp);
            check({tag, "_err"}, d_err, eexp);
            d_req = 1'b0;
         end
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
      check({tag, "_wecnt"}, we_cnt, (we && !eexp) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int k;
      int n;
      int pulses;
      logic [31:0] last_addr;
      logic [31:0] oor_addr;

      last_addr = (RAM_SIZE - 1) * 4;
      oor_addr  = RAM_SIZE * 4;

      // Reset while both ports request.
      HRESET     = 1'b1;
      i_req      = 1'b1;
      i_addr     = 32'h0000_0080;
      d_req      = 1'b1;
      d_we       = 1'b0;
      d_addr     = 32'h0000_0040;
      d_wdata    = 32'hFFFF_0000;
      mem_hready = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      repeat (3) @(negedge HCLK);
      check("rst_i_ready", i_ready, 1'b0);
      check("rst_d_ready", d_ready, 1'b0);
      check("rst_i_err", i_err, 1'b0);
      check("rst_d_err", d_err, 1'b0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);

      // Release: data wins first, the waiting fetch follows.
      HRESET = 1'b0;
      d_access(1'b0, 32'h0000_0040, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0, 2, "rel_d");
      i_access(32'h0000_0080, 32'h5555_AAAA, 1'b0, 2, "rel_i");
      @(negedge HCLK);

      // Plain fetch, write, read.
      mem_rdata = 32'hDEAD_BEEF;
      i_access(32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 2, "fetch");
      @(negedge HCLK);
      d_access(1'b1, 32'h0000_0020, 32'h1234_5678, 32'd0, 1'b0, 2, "wr");
      @(negedge HCLK);
      mem_rdata = 32'hCAFE_F00D;
      d_access(1'b0, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, 1'b0, 2, "rd");
      i_access(32'h0000_0013, 32'hCAFE_F00D, 1'b0, 2, "fetch_unaligned");

      // Range boundaries.
      d_access(1'b0, last_addr, 32'd0, 32'hCAFE_F00D, 1'b0, 2, "rd_last");
      d_access(1'b0, oor_addr, 32'd0, 32'd0, 1'b1, 1, "rd_oor");
      d_access(1'b1, oor_addr, 32'h1111_2222, 32'd0, 1'b1, 1, "wr_oor");
      i_access(oor_addr, 32'd0, 1'b1, 1, "i_oor");
      i_access(32'hFFFF_FFFC, 32'd0, 1'b1, 1, "i_oor_top");
      @(negedge HCLK);

      // SRAM wait states during a fetch response.
      mem_hready = 1'b0;
      mem_rdata  = 32'hA5A5_0001;
      i_req      = 1'b1;
      i_addr     = 32'h0000_0200;
      pulses     = 0;
      repeat (4) begin
         @(negedge HCLK);
         if (i_ready) pulses++;
      end
      check("wait_no_pulse", pulses, 32'd0);
      mem_hready = 1'b1;
      #1;
      check("wait_ready", i_ready, 1'b1);
      check("wait_rdata", i_rdata, 32'hA5A5_0001);
      i_req = 1'b0;
      @(negedge HCLK);
      check("wait_single", i_ready, 1'b0);

      // Fairness with both requests held continuously.
      i_req     = 1'b1;
      i_addr    = 32'h0000_0400;
      d_req     = 1'b1;
      d_we      = 1'b0;
      d_addr    = 32'h0000_0800;
      mem_rdata = 32'h0BAD_F00D;
      k = 0;
      n = 0;
      while (k < 10 && n < 60) begin
         @(negedge HCLK);
         n++;
         if (i_ready || d_ready) begin
            check($sformatf("order%0d_excl", k), i_ready && d_ready, 1'b0);
            check($sformatf("order%0d_is_i", k), i_ready, (k % 5 == 4) ? 32'd1 : 32'd0);
            k++;
         end
      end
      if (k < 10) check("order_timeout", k, 32'd10);
      i_req = 1'b0;
      d_req = 1'b0;
      @(negedge HCLK);

      // Reset during a data response drops it silently.
      mem_hready = 1'b0;
      d_req      = 1'b1;
      d_we       = 1'b1;
      d_addr     = 32'h0000_0300;
      d_wdata    = 32'h7777_8888;
      @(negedge HCLK);
      check("rstmid_issue_we", mem_we, 1'b1);
      @(negedge HCLK);
      check("rstmid_resp_wait", d_ready, 1'b0);
      HRESET     = 1'b1;
      mem_hready = 1'b1;
      d_req      = 1'b0;
      #1;
      check("rstmid_no_pulse", d_ready, 1'b0);
      @(negedge HCLK);
      check("rstmid_idle_ready", d_ready, 1'b0);
      check("rstmid_mem_we", mem_we, 1'b0);
      check("rstmid_mem_addr", mem_addr, 32'd0);
      HRESET = 1'b0;
      @(negedge HCLK);
      check("rstmid_after_d", d_ready, 1'b0);
      check("rstmid_after_we", mem_we, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
